// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: hazard detection and operand-forward select generation for the 5-stage MIPS core.
// Latency: stall and every forward select are combinational from tracker state and D inputs; the tracker advances each clk.
// Backpressure: stall freezes F/D and injects a bubble into E; mult/div conflicts hold D until the unit is free.
//
// Ports:
//   clk, reset (async, active-low)
//   d_rs/d_rt, d_rs_tuse/d_rt_tuse : D-stage sources and when each is first needed (3 = never)
//   d_wa/d_tnew                    : D-stage destination (0 = none) and cycles-after-E until forwardable
//   d_md_use, e_md_start, e_md_div : HI/LO users in D and mult/div start in E
//   stall                          : freeze F/D, bubble into E
//   fwd_rs_d/fwd_rt_d, fwd_rs_e/fwd_rt_e, fwd_rt_m : 0 = RB, 1 = M ALU, 2 = W data, 3 = E early result
//   md_busy                        : mult/div unit occupied
module hazard_fwd_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_rs_tuse,
    input  logic [1:0] d_rt_tuse,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    input  logic       d_md_use,
    input  logic       e_md_start,
    input  logic       e_md_div,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic [1:0] fwd_rt_m,
    output logic       md_busy
);

    // Forward mux select codes shared with the datapath.
    localparam logic [1:0] SEL_RB    = 2'd0;
    localparam logic [1:0] SEL_ALU   = 2'd1;
    localparam logic [1:0] SEL_MUX   = 2'd2;
    localparam logic [1:0] SEL_ALUIN = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Counter wide enough for the longer latency, never narrower than 4 bits.
    localparam int MAX_LAT   = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CNT_W_MIN = $clog2(MAX_LAT + 1);
    localparam int CNT_W     = (CNT_W_MIN < 4) ? 4 : CNT_W_MIN;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);

    // E keeps both sources for the E-stage muxes. M only needs RT (store data);
    // its RS has no consumer so it is not kept. W results are always ready, so
    // only its destination is tracked.
    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } e_stage_t;

    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
        logic [4:0] rt;
    } m_stage_t;

    e_stage_t         e_q, e_d;
    m_stage_t         m_q, m_d;
    logic [4:0]       w_wa_q, w_wa_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic stall_raw;
    logic md_conflict;

    // A producer matches a source only for a nonzero register index, which
    // also makes bubbles (wa = 0) invisible.
    function automatic logic reg_hit(input logic [4:0] wa, input logic [4:0] src);
        return (src != 5'd0) && (wa == src);
    endfunction

    // A source stalls when an in-flight producer of it will not be ready by
    // the time the consumer needs it.
    function automatic logic src_stall(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input e_stage_t   e,
        input m_stage_t   m
    );
        logic hit;
        hit = 1'b0;
        if (tuse != TUSE_NONE) begin
            hit = (reg_hit(e.wa, src) && (e.tnew > tuse)) ||
                  (reg_hit(m.wa, src) && (m.tnew > tuse));
        end
        return hit;
    endfunction

    // Nearest matching producer decides; if it is not ready yet the select
    // falls back to RB (stall guarantees that value is never consumed).
    function automatic logic [1:0] sel_d(
        input logic [4:0] src,
        input e_stage_t   e,
        input m_stage_t   m,
        input logic [4:0] w_wa
    );
        logic [1:0] sel;
        sel = SEL_RB;
        if (reg_hit(e.wa, src)) begin
            sel = (e.tnew == 2'd0) ? SEL_ALUIN : SEL_RB;
        end else if (reg_hit(m.wa, src)) begin
            sel = (m.tnew == 2'd0) ? SEL_ALU : SEL_RB;
        end else if (reg_hit(w_wa, src)) begin
            sel = SEL_MUX;
        end
        return sel;
    endfunction

    function automatic logic [1:0] sel_e(
        input logic [4:0] src,
        input m_stage_t   m,
        input logic [4:0] w_wa
    );
        logic [1:0] sel;
        sel = SEL_RB;
        if (reg_hit(m.wa, src)) begin
            sel = (m.tnew == 2'd0) ? SEL_ALU : SEL_RB;
        end else if (reg_hit(w_wa, src)) begin
            sel = SEL_MUX;
        end
        return sel;
    endfunction

    function automatic logic [1:0] sel_m(input logic [4:0] src, input logic [4:0] w_wa);
        return reg_hit(w_wa, src) ? SEL_MUX : SEL_RB;
    endfunction

    assign md_busy = (md_cnt_q != '0);

    // Gated with reset so stall reads 0 while reset is held, even when the
    // raw D inputs (e.g. a HI/LO user next to a mult/div start) would assert it.
    always_comb begin
        md_conflict = d_md_use && (md_busy || e_md_start);
        stall_raw   = src_stall(d_rs, d_rs_tuse, e_q, m_q) ||
                      src_stall(d_rt, d_rt_tuse, e_q, m_q) ||
                      md_conflict;
        stall       = reset && stall_raw;
    end

    assign fwd_rs_d = sel_d(d_rs, e_q, m_q, w_wa_q);
    assign fwd_rt_d = sel_d(d_rt, e_q, m_q, w_wa_q);
    assign fwd_rs_e = sel_e(e_q.rs, m_q, w_wa_q);
    assign fwd_rt_e = sel_e(e_q.rt, m_q, w_wa_q);
    assign fwd_rt_m = sel_m(m_q.rt, w_wa_q);

    always_comb begin
        // A stalled D instruction stays put, so E receives a bubble.
        e_d = '0;
        if (!stall) begin
            e_d.wa   = d_wa;
            e_d.tnew = d_tnew;
            e_d.rs   = d_rs;
            e_d.rt   = d_rt;
        end

        // One stage closer to ready; saturate at 0.
        m_d.wa   = e_q.wa;
        m_d.rt   = e_q.rt;
        m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : (e_q.tnew - 2'd1);

        w_wa_d   = m_q.wa;

        // A start always (re)loads, even while a previous op is still running.
        md_cnt_d = md_cnt_q;
        if (e_md_start) begin
            md_cnt_d = e_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_wa_q   <= '0;
            md_cnt_q <= '0;
        end else begin
            e_q      <= e_d;
            m_q      <= m_d;
            w_wa_q   <= w_wa_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: randomized and directed stimulus for hazard_fwd_ctrl with a scoreboard.
// Latency: expected outputs are queued when inputs are driven and popped on the following falling edge.
// Backpressure: the model follows the DUT's stall (bubble into E); the driver never holds D on its own.
module tb_hazard_fwd_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       d_md_use, e_md_start, e_md_div;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

    hazard_fwd_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_rs_tuse (d_rs_tuse),
        .d_rt_tuse (d_rt_tuse),
        .d_wa      (d_wa),
        .d_tnew    (d_tnew),
        .d_md_use  (d_md_use),
        .e_md_start(e_md_start),
        .e_md_div  (e_md_div),
        .stall     (stall),
        .fwd_rs_d  (fwd_rs_d),
        .fwd_rt_d  (fwd_rt_d),
        .fwd_rs_e  (fwd_rs_e),
        .fwd_rt_e  (fwd_rt_e),
        .fwd_rt_m  (fwd_rt_m),
        .md_busy   (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rs; int rs_tuse; int rt; int rt_tuse; int wa; int tnew;
        bit md_use; bit md_start; bit md_div;
    } din_t;

    typedef struct {
        int stall; int fwd_rs_d; int fwd_rt_d; int fwd_rs_e; int fwd_rt_e; int fwd_rt_m; int md_busy;
    } exp_t;

    // One issued instruction; its position in hist gives its age past E.
    typedef struct { int wa; int tnew; int rs; int rt; } inst_t;

    inst_t hist[$];       // hist[0] = E, hist[1] = M, hist[2] = W
    exp_t  exp_q[$];
    din_t  cur_in;
    int    cur_stall;
    int    cyc;
    int    md_start_cyc;
    int    md_lat;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic din_t mk(input int rs, input int rs_tuse, input int rt, input int rt_tuse,
                                input int wa, input int tnew,
                                input bit md_use, input bit md_start, input bit md_div);
        din_t d;
        d.rs = rs; d.rs_tuse = rs_tuse; d.rt = rt; d.rt_tuse = rt_tuse;
        d.wa = wa; d.tnew = tnew; d.md_use = md_use; d.md_start = md_start; d.md_div = md_div;
        return d;
    endfunction

    function automatic din_t rnd();
        return mk($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 7), $urandom_range(0, 2),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
    endfunction

    // Cycles still needed before instruction at age k can forward; W is always ready.
    function automatic int rem_tnew(input int k);
        int r;
        if (k >= 2) return 0;
        r = hist[k].tnew - k;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit md_busy_model();
        return (cyc > md_start_cyc) && (cyc <= md_start_cyc + md_lat);
    endfunction

    function automatic bit src_blocked(input int s, input int tuse);
        if (tuse == 3 || s == 0) return 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (hist[k].wa == s && rem_tnew(k) > tuse) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Select from the nearest producer among ages first..last.
    function automatic int sel_for(input int s, input int first, input int last);
        if (s == 0) return 0;
        for (int k = first; k <= last; k++) begin
            if (hist[k].wa == s) begin
                if (rem_tnew(k) != 0) return 0;
                return (k == 0) ? 3 : ((k == 1) ? 1 : 2);
            end
        end
        return 0;
    endfunction

    function automatic exp_t predict(input din_t d);
        exp_t e;
        e = '{default: 0};
        if (reset) begin
            e.stall    = (src_blocked(d.rs, d.rs_tuse) || src_blocked(d.rt, d.rt_tuse) ||
                          (d.md_use && (md_busy_model() || d.md_start))) ? 1 : 0;
            e.fwd_rs_d = sel_for(d.rs, 0, 2);
            e.fwd_rt_d = sel_for(d.rt, 0, 2);
            e.fwd_rs_e = sel_for(hist[0].rs, 1, 2);
            e.fwd_rt_e = sel_for(hist[0].rt, 1, 2);
            e.fwd_rt_m = sel_for(hist[1].rt, 2, 2);
            e.md_busy  = md_busy_model() ? 1 : 0;
        end
        return e;
    endfunction

    task automatic reset_model();
        hist.delete();
        for (int k = 0; k < 3; k++) hist.push_back('{wa: 0, tnew: 0, rs: 0, rt: 0});
        md_start_cyc = -1000;
        md_lat       = 0;
    endtask

    task automatic drive(input din_t d);
        d_rs       = 5'(d.rs);
        d_rt       = 5'(d.rt);
        d_rs_tuse  = 2'(d.rs_tuse);
        d_rt_tuse  = 2'(d.rt_tuse);
        d_wa       = 5'(d.wa);
        d_tnew     = 2'(d.tnew);
        d_md_use   = d.md_use;
        e_md_start = d.md_start;
        e_md_div   = d.md_div;
    endtask

    // Advance one clock: retire the previous cycle into the model, then drive
    // the new D inputs and queue what the DUT should show this cycle.
    task automatic step(input din_t d);
        inst_t x;
        exp_t  e;
        @(posedge clk);
        if (!reset) begin
            reset_model();
        end else begin
            if (cur_stall != 0) x = '{wa: 0, tnew: 0, rs: 0, rt: 0};
            else                x = '{wa: cur_in.wa, tnew: cur_in.tnew, rs: cur_in.rs, rt: cur_in.rt};
            hist.push_front(x);
            hist.delete(3);
            if (cur_in.md_start) begin
                md_start_cyc = cyc;
                md_lat       = cur_in.md_div ? DIV_LAT : MULT_LAT;
            end
        end
        cyc++;
        #1;
        drive(d);
        cur_in    = d;
        e         = predict(d);
        cur_stall = e.stall;
        exp_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},    32'(stall),    0);
        chk({tag, "_md_busy"},  32'(md_busy),  0);
        chk({tag, "_fwd_rs_d"}, 32'(fwd_rs_d), 0);
        chk({tag, "_fwd_rt_d"}, 32'(fwd_rt_d), 0);
        chk({tag, "_fwd_rs_e"}, 32'(fwd_rs_e), 0);
        chk({tag, "_fwd_rt_e"}, 32'(fwd_rt_e), 0);
        chk({tag, "_fwd_rt_m"}, 32'(fwd_rt_m), 0);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_stall",    32'(stall),    32'(mon_e.stall));
            chk("sb_fwd_rs_d", 32'(fwd_rs_d), 32'(mon_e.fwd_rs_d));
            chk("sb_fwd_rt_d", 32'(fwd_rt_d), 32'(mon_e.fwd_rt_d));
            chk("sb_fwd_rs_e", 32'(fwd_rs_e), 32'(mon_e.fwd_rs_e));
            chk("sb_fwd_rt_e", 32'(fwd_rt_e), 32'(mon_e.fwd_rt_e));
            chk("sb_fwd_rt_m", 32'(fwd_rt_m), 32'(mon_e.fwd_rt_m));
            chk("sb_md_busy",  32'(md_busy),  32'(mon_e.md_busy));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        din_t nop, mfhi;
        exp_t zero_e;
        int   busy_cnt;
        int   stall_cnt;

        nop    = mk(0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        mfhi   = mk(0, 3, 0, 3, 0, 0, 1'b1, 1'b0, 1'b0);
        zero_e = '{default: 0};

        reset     = 1'b0;
        cyc       = 0;
        cur_in    = nop;
        cur_stall = 0;
        reset_model();
        drive(nop);

        #2;
        chk_all_zero("rst");
        repeat (2) step(nop);
        #2 reset = 1'b1;

        // Load-use: lw $8 then a consumer needing $8 in E.
        repeat (3) step(nop);
        step(mk(0, 3, 0, 3, 8, 2, 1'b0, 1'b0, 1'b0));
        step(mk(8, 1, 0, 3, 10, 1, 1'b0, 1'b0, 1'b0));
        #1 chk("lu_stall_first", 32'(stall), 1);
        step(mk(8, 1, 0, 3, 10, 1, 1'b0, 1'b0, 1'b0));
        #1 chk("lu_stall_second", 32'(stall), 0);
        step(nop);
        #1 chk("lu_fwd_rs_e", 32'(fwd_rs_e), 2);

        // ALU chain on $9.
        repeat (3) step(nop);
        step(mk(0, 3, 0, 3, 9, 1, 1'b0, 1'b0, 1'b0));
        step(mk(9, 1, 0, 3, 11, 1, 1'b0, 1'b0, 1'b0));
        #1 chk("alu_no_stall", 32'(stall), 0);
        step(mk(9, 1, 0, 3, 12, 1, 1'b0, 1'b0, 1'b0));
        #1 chk("alu_fwd_rs_e_m", 32'(fwd_rs_e), 1);
        step(nop);
        #1 chk("alu_fwd_rs_e_w", 32'(fwd_rs_e), 2);

        // D-stage branch against jal / add writing $31.
        repeat (3) step(nop);
        step(mk(0, 3, 0, 3, 31, 0, 1'b0, 1'b0, 1'b0));
        step(mk(31, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0));
        #1 chk("br_jal_fwd_rs_d", 32'(fwd_rs_d), 3);
        chk("br_jal_stall", 32'(stall), 0);
        repeat (3) step(nop);
        step(mk(0, 3, 0, 3, 31, 1, 1'b0, 1'b0, 1'b0));
        step(mk(31, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0));
        #1 chk("br_add_stall", 32'(stall), 1);

        // Priority: $5 producers in M and W; then a $0 producer.
        repeat (3) step(nop);
        step(mk(0, 3, 0, 3, 5, 0, 1'b0, 1'b0, 1'b0));
        step(mk(0, 3, 0, 3, 5, 0, 1'b0, 1'b0, 1'b0));
        step(nop);
        step(mk(5, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0));
        #1 chk("prio_fwd_rs_d", 32'(fwd_rs_d), 1);
        repeat (3) step(nop);
        step(mk(0, 3, 0, 3, 0, 2, 1'b0, 1'b0, 1'b0));
        step(mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0));
        #1 chk("r0_stall", 32'(stall), 0);
        chk("r0_fwd_rs_d", 32'(fwd_rs_d), 0);

        // Divide start with mfhi waiting in D.
        repeat (12) step(nop);
        busy_cnt  = 0;
        stall_cnt = 0;
        step(mk(0, 3, 0, 3, 0, 0, 1'b1, 1'b1, 1'b1));
        #1;
        busy_cnt  += int'(md_busy);
        stall_cnt += int'(stall);
        repeat (15) begin
            step(mfhi);
            #1;
            busy_cnt  += int'(md_busy);
            stall_cnt += int'(stall);
        end
        chk("div_busy_cycles", 32'(busy_cnt), DIV_LAT);
        chk("mfhi_stall_cycles", 32'(stall_cnt), DIV_LAT + 1);

        // Randomized traffic.
        repeat (2000) step(rnd());

        // Asynchronous reset in the middle of a divide (count = 6).
        repeat (12) step(nop);
        step(mk(0, 3, 0, 3, 0, 0, 1'b0, 1'b1, 1'b1));
        repeat (3) step(nop);
        step(mk(0, 3, 0, 3, 7, 0, 1'b0, 1'b0, 1'b0));
        step(mk(7, 0, 0, 3, 0, 0, 1'b1, 1'b0, 1'b0));
        #1 chk("pre_rst_md_busy", 32'(md_busy), 1);
        chk("pre_rst_stall", 32'(stall), 1);
        chk("pre_rst_fwd_rs_d", 32'(fwd_rs_d), 3);
        #1 reset = 1'b0;
        #1 chk_all_zero("arst");
        void'(exp_q.pop_back());
        exp_q.push_back(zero_e);
        cur_stall = 0;
        cur_in    = nop;
        drive(nop);
        repeat (2) step(nop);
        #2 reset = 1'b1;

        repeat (500) step(rnd());

        repeat (2) @(negedge clk);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
